tap_controller: RTL and testbench

TAP_CONTROLLER -- requirements
Module: tap_controller

---
 rtl/tap_controller.sv | 212 +++++++++++++++++++++
 tb/tb_tap_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller with IDCODE, BYPASS, TCP_CTRL/TCP_STATUS data
// registers and an IJTAG access port driven from the DR scan phases.
module tap_controller #(
    parameter logic [31:0] IDCODE_VALUE     = 32'h1CAFE0BF,
    parameter logic [31:0] TCP_STATUS_VALUE = 32'hDEADBEEF
) (
    input  logic TCK,
    input  logic TRST,
    input  logic TMS,
    input  logic TDI,
    output logic TDO,
    output logic ijtag_select,
    output logic ijtag_capture,
    output logic ijtag_shift,
    output logic ijtag_update,
    output logic ijtag_tdi,
    input  logic ijtag_tdo
);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR_SCAN   = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR_SCAN   = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_t;

    typedef enum logic [2:0] {
        DR_BYPASS = 3'd0,
        DR_IDCODE = 3'd1,
        DR_CTRL   = 3'd2,
        DR_STATUS = 3'd3,
        DR_IJTAG  = 3'd4
    } dr_sel_t;

    localparam logic [3:0] IR_BYPASS     = 4'h0;
    localparam logic [3:0] IR_IDCODE     = 4'h1;
    localparam logic [3:0] IR_TCP_CTRL   = 4'h8;
    localparam logic [3:0] IR_TCP_STATUS = 4'h9;
    localparam logic [3:0] IR_IJTAG      = 4'hA;
    localparam logic [3:0] IR_CAPTURE    = 4'b0001;

    tap_state_t  tap_state;
    tap_state_t  w_tap_state_nxt;
    logic [3:0]  r_ir;
    logic [3:0]  r_ir_shift;
    logic [31:0] r_dr_shift;
    logic [31:0] r_tcp_ctrl;
    logic        r_bypass;
    logic        r_tdo;
    logic [3:0]  w_ir_active;
    dr_sel_t     w_dr_sel;
    logic        w_tdo_nxt;

    // TAP state register
    always_ff @(posedge TCK) begin
        if (TRST) begin
            tap_state <= TEST_LOGIC_RESET;
        end else begin
            tap_state <= w_tap_state_nxt;
        end
    end

    // Standard 1149.1 next-state function of TMS
    always_comb begin
        w_tap_state_nxt = tap_state;
        case (tap_state)
            TEST_LOGIC_RESET: w_tap_state_nxt = TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    w_tap_state_nxt = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   w_tap_state_nxt = TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       w_tap_state_nxt = TMS ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         w_tap_state_nxt = TMS ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         w_tap_state_nxt = TMS ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         w_tap_state_nxt = TMS ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         w_tap_state_nxt = TMS ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        w_tap_state_nxt = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   w_tap_state_nxt = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       w_tap_state_nxt = TMS ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         w_tap_state_nxt = TMS ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         w_tap_state_nxt = TMS ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         w_tap_state_nxt = TMS ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         w_tap_state_nxt = TMS ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        w_tap_state_nxt = TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          w_tap_state_nxt = TEST_LOGIC_RESET;
        endcase
    end

    // Active instruction; TLR overrides the stored IR immediately on entry
    always_comb begin
        w_ir_active = r_ir;
        if (tap_state == TEST_LOGIC_RESET) begin
            w_ir_active = IR_IDCODE;
        end else begin
            w_ir_active = r_ir;
        end
    end

    // Instruction decode to data register selection, unknown codes map to BYPASS
    always_comb begin
        w_dr_sel = DR_BYPASS;
        case (w_ir_active)
            IR_BYPASS:     w_dr_sel = DR_BYPASS;
            IR_IDCODE:     w_dr_sel = DR_IDCODE;
            IR_TCP_CTRL:   w_dr_sel = DR_CTRL;
            IR_TCP_STATUS: w_dr_sel = DR_STATUS;
            IR_IJTAG:      w_dr_sel = DR_IJTAG;
            default:       w_dr_sel = DR_BYPASS;
        endcase
    end

    // Instruction register: capture / shift / update stages
    always_ff @(posedge TCK) begin
        if (TRST) begin
            r_ir       <= IR_IDCODE;
            r_ir_shift <= IR_CAPTURE;
        end else begin
            case (tap_state)
                TEST_LOGIC_RESET: r_ir       <= IR_IDCODE;
                CAPTURE_IR:       r_ir_shift <= IR_CAPTURE;
                SHIFT_IR:         r_ir_shift <= {TDI, r_ir_shift[3:1]};
                UPDATE_IR:        r_ir       <= r_ir_shift;
                default:          begin end
            endcase
        end
    end

    // Data registers; TCP_CTRL survives a TMS-driven TLR and only clears on TRST
    always_ff @(posedge TCK) begin
        if (TRST) begin
            r_dr_shift <= 32'h0000_0000;
            r_tcp_ctrl <= 32'h0000_0000;
            r_bypass   <= 1'b0;
        end else begin
            case (tap_state)
                CAPTURE_DR: begin
                    case (w_dr_sel)
                        DR_BYPASS: r_bypass   <= 1'b0;
                        DR_IDCODE: r_dr_shift <= IDCODE_VALUE;
                        DR_CTRL:   r_dr_shift <= r_tcp_ctrl;
                        DR_STATUS: r_dr_shift <= TCP_STATUS_VALUE;
                        default:   begin end
                    endcase
                end
                SHIFT_DR: begin
                    case (w_dr_sel)
                        DR_BYPASS: r_bypass   <= TDI;
                        DR_IDCODE: r_dr_shift <= {TDI, r_dr_shift[31:1]};
                        DR_CTRL:   r_dr_shift <= {TDI, r_dr_shift[31:1]};
                        DR_STATUS: r_dr_shift <= {TDI, r_dr_shift[31:1]};
                        default:   begin end
                    endcase
                end
                UPDATE_DR: begin
                    if (w_dr_sel == DR_CTRL) begin
                        r_tcp_ctrl <= r_dr_shift;
                    end else begin
                        r_tcp_ctrl <= r_tcp_ctrl;
                    end
                end
                default: begin end
            endcase
        end
    end

    // Serial output source selection for the falling-edge TDO flop
    always_comb begin
        w_tdo_nxt = 1'b0;
        if (tap_state == SHIFT_IR) begin
            w_tdo_nxt = r_ir_shift[0];
        end else if (tap_state == SHIFT_DR) begin
            case (w_dr_sel)
                DR_BYPASS: w_tdo_nxt = r_bypass;
                DR_IJTAG:  w_tdo_nxt = ijtag_tdo;
                default:   w_tdo_nxt = r_dr_shift[0];
            endcase
        end else begin
            w_tdo_nxt = 1'b0;
        end
    end

    // TDO changes on falling TCK so the host samples it on the next rising edge
    always_ff @(negedge TCK) begin
        if (TRST) begin
            r_tdo <= 1'b0;
        end else begin
            r_tdo <= w_tdo_nxt;
        end
    end

    assign TDO = r_tdo;

    // IJTAG phase strobes follow the TAP state directly
    always_comb begin
        ijtag_select  = (w_ir_active == IR_IJTAG);
        ijtag_capture = ijtag_select && (tap_state == CAPTURE_DR);
        ijtag_shift   = ijtag_select && (tap_state == SHIFT_DR);
        ijtag_update  = ijtag_select && (tap_state == UPDATE_DR);
        ijtag_tdi     = TDI;
    end

endmodule

// File: tb/tb_tap_controller.sv
// Randomised bench for tap_controller against a table-driven TAP reference model.
module tb_tap_controller;

    logic TCK = 1'b0;
    logic TRST = 1'b0;
    logic TMS = 1'b0;
    logic TDI = 1'b0;
    logic ijtag_tdo = 1'b0;
    logic TDO;
    logic ijtag_select, ijtag_capture, ijtag_shift, ijtag_update, ijtag_tdi;

    tap_controller dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .ijtag_select(ijtag_select), .ijtag_capture(ijtag_capture),
        .ijtag_shift(ijtag_shift), .ijtag_update(ijtag_update),
        .ijtag_tdi(ijtag_tdi), .ijtag_tdo(ijtag_tdo)
    );

    always #5 TCK = ~TCK;

    int n_checks = 0;
    int n_errors = 0;
    logic last_tdo;

    // Reference model: states named and chained by lookup tables
    string st_name [16] = '{"TEST_LOGIC_RESET", "RUN_TEST_IDLE", "SELECT_DR_SCAN", "CAPTURE_DR",
                            "SHIFT_DR", "EXIT1_DR", "PAUSE_DR", "EXIT2_DR", "UPDATE_DR",
                            "SELECT_IR_SCAN", "CAPTURE_IR", "SHIFT_IR", "EXIT1_IR", "PAUSE_IR",
                            "EXIT2_IR", "UPDATE_IR"};
    int nxt_tms0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt_tms1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int          m_state = 0;
    logic [3:0]  m_ir = 4'h1;
    logic [3:0]  m_irsh = 4'h1;
    logic [31:0] m_dr = 32'h0;
    logic [31:0] m_ctrl = 32'h0;
    logic        m_byp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int state_idx(input string s);
        for (int i = 0; i < 16; i++) begin
            if (st_name[i] == s) return i;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_active();
        return (m_state == 0) ? 4'h1 : m_ir;
    endfunction

    // 0 bypass, 1 idcode, 2 ctrl, 3 status, 4 ijtag
    function automatic int m_kind();
        case (m_active())
            4'h1:    return 1;
            4'h8:    return 2;
            4'h9:    return 3;
            4'hA:    return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(input bit trst, input bit tms, input bit tdi);
        if (trst) begin
            m_state = 0; m_ir = 4'h1; m_irsh = 4'h1;
            m_ctrl = 32'h0; m_dr = 32'h0; m_byp = 1'b0;
        end else begin
            case (m_state)
                0:  m_ir = 4'h1;
                10: m_irsh = 4'b0001;
                11: m_irsh = {tdi, m_irsh[3:1]};
                15: m_ir = m_irsh;
                3: begin
                    case (m_kind())
                        0: m_byp = 1'b0;
                        1: m_dr = 32'h1CAFE0BF;
                        2: m_dr = m_ctrl;
                        3: m_dr = 32'hDEADBEEF;
                        default: ;
                    endcase
                end
                4: begin
                    if (m_kind() == 0) m_byp = tdi;
                    else if (m_kind() != 4) m_dr = (m_dr >> 1) | ({31'h0, tdi} << 31);
                end
                8: if (m_kind() == 2) m_ctrl = m_dr;
                default: ;
            endcase
            m_state = tms ? nxt_tms1[m_state] : nxt_tms0[m_state];
        end
    endtask

    task automatic step(input bit trst, input bit tms, input bit tdi, input bit itdo);
        logic [4:0] exp_ij;
        logic       sel;
        logic       exp_tdo;
        TRST = trst; TMS = tms; TDI = tdi; ijtag_tdo = itdo;
        @(posedge TCK);
        model_edge(trst, tms, tdi);
        #1;
        sel = (m_active() == 4'hA);
        exp_ij = {sel, sel && m_state == 3, sel && m_state == 4, sel && m_state == 8, tdi};
        check_eq("state", state_idx(dut.tap_state.name()), m_state);
        check_eq("ijtag", {ijtag_select, ijtag_capture, ijtag_shift, ijtag_update, ijtag_tdi}, exp_ij);
        if (trst) exp_tdo = 1'b0;
        else if (m_state == 11) exp_tdo = m_irsh[0];
        else if (m_state == 4) exp_tdo = (m_kind() == 4) ? itdo : (m_kind() == 0) ? m_byp : m_dr[0];
        else exp_tdo = 1'b0;
        @(negedge TCK);
        #1;
        last_tdo = TDO;
        check_eq("tdo", TDO, exp_tdo);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic go_idle();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rb(), rb());
        step(1'b0, 1'b0, rb(), rb());
    endtask

    task automatic load_ir(input logic [3:0] code);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, (i == 3), code[i], 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic scan_dr(input logic [31:0] din, output logic [31:0] dout);
        step(1'b0, 1'b1, 1'b0, rb());
        step(1'b0, 1'b0, 1'b0, rb());
        step(1'b0, 1'b0, 1'b0, rb());
        dout[0] = last_tdo;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, (i == 31), din[i], rb());
            if (i < 31) dout[i + 1] = last_tdo;
        end
        step(1'b0, 1'b1, 1'b0, rb());
        step(1'b0, 1'b0, 1'b0, rb());
    endtask

    logic [31:0] d;
    logic [3:0]  code;

    initial begin
        // Reset and TLR/RTI entry
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("rst_tdo", TDO, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("tlr", state_idx(dut.tap_state.name()), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rti", state_idx(dut.tap_state.name()), 1);

        // Default IDCODE without an IR scan
        scan_dr(32'h0, d);
        check_eq("idcode", d, 32'h1CAFE0BF);

        // BYPASS: one-bit delay, first bit 0
        load_ir(4'h0);
        scan_dr(32'hFFFF_FFFF, d);
        check_eq("bypass", d, 32'hFFFF_FFFE);

        // TCP_CTRL round trip, survives TMS reset, cleared by TRST
        load_ir(4'h8);
        scan_dr(32'hA5A55A5A, d);
        scan_dr(32'hA5A55A5A, d);
        check_eq("ctrl_rd", d, 32'hA5A55A5A);
        go_idle();
        load_ir(4'h8);
        scan_dr(32'h1234_5678, d);
        check_eq("ctrl_tms_rst", d, 32'hA5A55A5A);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        load_ir(4'h8);
        scan_dr(32'h0, d);
        check_eq("ctrl_trst", d, 32'h0);

        // TCP_STATUS is read-only
        load_ir(4'h9);
        scan_dr(32'h0, d);
        check_eq("status1", d, 32'hDEADBEEF);
        scan_dr(32'h0, d);
        check_eq("status2", d, 32'hDEADBEEF);

        // IJTAG access and full traversal through pause/exit2 states
        load_ir(4'hA);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ij_cap", {ijtag_select, ijtag_capture}, 2'b11);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("ij_shift", ijtag_shift, 1'b1);
        check_eq("ij_tdo1", last_tdo, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("ij_tdo0", last_tdo, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("ij_update", ijtag_update, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("trav_end", state_idx(dut.tap_state.name()), 1);

        // Randomised IR loads, scans and free TMS walks with rare TRST
        for (int k = 0; k < 60; k++) begin
            go_idle();
            case ($urandom_range(0, 5))
                0: code = 4'h0;
                1: code = 4'h1;
                2: code = 4'h8;
                3: code = 4'h9;
                4: code = 4'hA;
                default: code = 4'($urandom_range(0, 15));
            endcase
            load_ir(code);
            scan_dr($urandom(), d);
            for (int j = 0; j < 30; j++) begin
                step(($urandom_range(0, 63) == 0), rb(), rb(), rb());
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
